multichannel_attenuation_mixer: RTL and testbench

Parametrised stereo attenuation mixer for the audio output path. It sums NUM_SRC stereo sources through a full 2x2 cross-feed matrix per source (l2l, r2l, l2r, r2r) using one time-multiplexed multiplier. Factor changes ramp smoothly per sample to suppress zipper noise. Outputs are saturated symmetrically. It sits between the per-source audio generators (CDIC, MPEG, future sources) and the audio output.

---
 rtl/mixer_pkg.sv | 39 +++
 rtl/mixer_factor_ramp.sv | 63 ++++++
 rtl/multichannel_attenuation_mixer.sv | 147 ++++++++++++++
 tb/tb_multichannel_attenuation_mixer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mixer_pkg.sv
// Shared mixer types and the accumulator-to-sample shift/saturate helper.
package mixer_pkg;

  typedef enum logic [1:0] {
    COEF_L2L = 2'd0,
    COEF_R2L = 2'd1,
    COEF_L2R = 2'd2,
    COEF_R2R = 2'd3
  } coef_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC_L = 2'd1,
    MAC_R = 2'd2,
    WRITE = 2'd3
  } mix_state_e;

  localparam int unsigned SAT_ACC_W = 64;

  // Arithmetic shift by frac_w, then clamp symmetrically to +/-(2^(out_w-1)-1).
  function automatic logic signed [SAT_ACC_W-1:0] sat_shift(
    input logic signed [SAT_ACC_W-1:0] acc,
    input int unsigned                 frac_w,
    input int unsigned                 out_w
  );
    logic signed [SAT_ACC_W-1:0] shifted;
    logic signed [SAT_ACC_W-1:0] lim;
    shifted = acc >>> frac_w;
    lim     = (SAT_ACC_W'(1) <<< (out_w - 1)) - SAT_ACC_W'(1);
    if (shifted > lim) begin
      return lim;
    end
    if (shifted < -lim) begin
      return -lim;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/mixer_factor_ramp.sv
// Target/current factor storage; current factors slew toward targets once per step.
module mixer_factor_ramp #(
  parameter int unsigned NUM_COEF  = 8,
  parameter int unsigned FACTOR_W  = 8,
  parameter int unsigned RAMP_STEP = 4,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         cfg_we,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [FACTOR_W-1:0]          cfg_data,
  input  logic                         step,
  output logic [NUM_COEF*FACTOR_W-1:0] cur_factors
);

  logic [FACTOR_W-1:0] tgt_q [NUM_COEF];
  logic [FACTOR_W-1:0] cur_q [NUM_COEF];
  logic [FACTOR_W-1:0] cur_d [NUM_COEF];

  function automatic logic [FACTOR_W-1:0] ramp_next(
    input logic [FACTOR_W-1:0] cur,
    input logic [FACTOR_W-1:0] tgt
  );
    logic [FACTOR_W-1:0] diff;
    if (RAMP_STEP == 0 || cur == tgt) begin
      return tgt;
    end
    if (tgt > cur) begin
      diff = tgt - cur;
      return (32'(diff) > RAMP_STEP) ? cur + FACTOR_W'(RAMP_STEP) : tgt;
    end
    diff = cur - tgt;
    return (32'(diff) > RAMP_STEP) ? cur - FACTOR_W'(RAMP_STEP) : tgt;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_COEF; i++) begin
      cur_d[i] = ramp_next(cur_q[i], tgt_q[i]);
      cur_factors[i*FACTOR_W +: FACTOR_W] = cur_q[i];
    end
  end

  // Writes touch targets only; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
      end
    end else begin
      if (cfg_we && (32'(cfg_addr) < NUM_COEF)) begin
        tgt_q[cfg_addr] <= cfg_data;
      end
      if (step) begin
        for (int unsigned i = 0; i < NUM_COEF; i++) begin
          cur_q[i] <= cur_d[i];
        end
      end
    end
  end

endmodule

// File: rtl/multichannel_attenuation_mixer.sv
// Stereo cross-feed mixer: NUM_SRC sources through a 2x2 gain matrix on one shared MAC.
module multichannel_attenuation_mixer
  import mixer_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned SAMPLE_W  = 16,
  parameter int unsigned FACTOR_W  = 8,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          sample_strobe,
  input  logic [NUM_SRC*SAMPLE_W-1:0]   src_left_in,
  input  logic [NUM_SRC*SAMPLE_W-1:0]   src_right_in,
  input  logic                          mute,
  input  logic                          cfg_we,
  input  logic [$clog2(4*NUM_SRC)-1:0]  cfg_addr,
  input  logic [FACTOR_W-1:0]           cfg_data,
  input  logic                          overrun_clr,
  output logic signed [SAMPLE_W-1:0]    audio_left_out,
  output logic signed [SAMPLE_W-1:0]    audio_right_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int unsigned NUM_COEF = 4 * NUM_SRC;
  localparam int unsigned ADDR_W   = $clog2(NUM_COEF);
  localparam int unsigned MAC_LEN  = 2 * NUM_SRC;
  localparam int unsigned CNT_W    = $clog2(MAC_LEN);
  localparam int unsigned PROD_W   = SAMPLE_W + FACTOR_W + 1;
  localparam int unsigned ACC_W    = PROD_W + $clog2(MAC_LEN);

  mix_state_e                   state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic [NUM_SRC*SAMPLE_W-1:0]  left_snap_q;
  logic [NUM_SRC*SAMPLE_W-1:0]  right_snap_q;
  logic [NUM_COEF*FACTOR_W-1:0] coef_snap_q;
  logic                         mute_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [ACC_W-1:0]      left_res_q;

  logic [NUM_COEF*FACTOR_W-1:0] cur_factors_c;
  logic                         accept_c;
  logic                         last_c;
  int unsigned                  src_idx_c;
  coef_e                        coef_sel_c;
  logic signed [SAMPLE_W-1:0]   mul_a_c;
  logic signed [FACTOR_W:0]     mul_b_c;
  logic signed [PROD_W-1:0]     prod_c;
  logic signed [ACC_W-1:0]      acc_next_c;

  assign accept_c = sample_strobe && (state_q == IDLE);
  assign last_c   = (cnt_q == CNT_W'(MAC_LEN - 1));

  mixer_factor_ramp #(
    .NUM_COEF (NUM_COEF),
    .FACTOR_W (FACTOR_W),
    .RAMP_STEP(RAMP_STEP),
    .ADDR_W   (ADDR_W)
  ) u_ramp (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .step       (accept_c),
    .cur_factors(cur_factors_c)
  );

  // Even slots take the left sample, odd slots the right; MAC_R selects the *2R coefs.
  always_comb begin
    src_idx_c  = 32'(cnt_q) >> 1;
    coef_sel_c = coef_e'({state_q == MAC_R, cnt_q[0]});
    mul_a_c    = cnt_q[0] ? right_snap_q[src_idx_c*SAMPLE_W +: SAMPLE_W]
                          : left_snap_q[src_idx_c*SAMPLE_W +: SAMPLE_W];
    mul_b_c    = {1'b0, coef_snap_q[(src_idx_c*4 + 32'(coef_sel_c))*FACTOR_W +: FACTOR_W]};
    prod_c     = PROD_W'(mul_a_c) * PROD_W'(mul_b_c);
    if (cnt_q == '0) begin
      acc_next_c = ACC_W'(prod_c);
    end else begin
      acc_next_c = acc_q + ACC_W'(prod_c);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      left_snap_q     <= '0;
      right_snap_q    <= '0;
      coef_snap_q     <= '0;
      mute_q          <= 1'b0;
      acc_q           <= '0;
      left_res_q      <= '0;
      audio_left_out  <= '0;
      audio_right_out <= '0;
      out_valid       <= 1'b0;
      busy            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_strobe && (state_q != IDLE)) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (sample_strobe) begin
            left_snap_q  <= src_left_in;
            right_snap_q <= src_right_in;
            coef_snap_q  <= cur_factors_c;
            mute_q       <= mute;
            cnt_q        <= '0;
            busy         <= 1'b1;
            state_q      <= MAC_L;
          end
        end
        MAC_L: begin
          acc_q <= acc_next_c;
          cnt_q <= last_c ? '0 : cnt_q + CNT_W'(1);
          if (last_c) begin
            left_res_q <= acc_next_c;
            state_q    <= MAC_R;
          end
        end
        MAC_R: begin
          acc_q <= acc_next_c;
          cnt_q <= last_c ? '0 : cnt_q + CNT_W'(1);
          if (last_c) begin
            state_q <= WRITE;
          end
        end
        WRITE: begin
          audio_left_out  <= mute_q ? '0 : SAMPLE_W'(sat_shift(64'(left_res_q), FACTOR_W, SAMPLE_W));
          audio_right_out <= mute_q ? '0 : SAMPLE_W'(sat_shift(64'(acc_q), FACTOR_W, SAMPLE_W));
          out_valid       <= 1'b1;
          busy            <= 1'b0;
          state_q         <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multichannel_attenuation_mixer.sv
// Scoreboard bench: two mixers (instant and ramped factors) against an arithmetic model.
module tb_multichannel_attenuation_mixer;

  localparam int NS = 2;
  localparam int SW = 16;
  localparam int FW = 8;

  logic               clk;
  logic               reset_n;
  logic               sample_strobe;
  logic [NS*SW-1:0]   src_left_in;
  logic [NS*SW-1:0]   src_right_in;
  logic               mute;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic [FW-1:0]      cfg_data;
  logic               overrun_clr;
  logic signed [SW-1:0] lo [2];
  logic signed [SW-1:0] ro [2];
  logic               ov [2];
  logic               bz [2];
  logic               orun [2];

  multichannel_attenuation_mixer #(.NUM_SRC(NS), .SAMPLE_W(SW), .FACTOR_W(FW), .RAMP_STEP(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .src_left_in(src_left_in), .src_right_in(src_right_in), .mute(mute),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .overrun_clr(overrun_clr),
    .audio_left_out(lo[0]), .audio_right_out(ro[0]), .out_valid(ov[0]),
    .busy(bz[0]), .overrun(orun[0])
  );

  multichannel_attenuation_mixer #(.NUM_SRC(NS), .SAMPLE_W(SW), .FACTOR_W(FW), .RAMP_STEP(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .sample_strobe(sample_strobe),
    .src_left_in(src_left_in), .src_right_in(src_right_in), .mute(mute),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .overrun_clr(overrun_clr),
    .audio_left_out(lo[1]), .audio_right_out(ro[1]), .out_valid(ov[1]),
    .busy(bz[1]), .overrun(orun[1])
  );

  typedef struct {
    int l;
    int r;
    int due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   npass    = 0;
  int   vcnt [2] = '{0, 0};
  int   tgt [2][8];
  int   cur [2][8];
  int   rstep [2] = '{0, 4};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: compare each out_valid against the oldest expected pass.
  task automatic mon_compare(input int d, input exp_t e);
    check($sformatf("dut%0d_left", d), int'(lo[d]), e.l);
    check($sformatf("dut%0d_right", d), int'(ro[d]), e.r);
    check($sformatf("dut%0d_latency", d), cyc, e.due);
    check($sformatf("dut%0d_busy_at_valid", d), int'(bz[d]), 0);
  endtask

  always @(negedge clk) begin
    if (ov[0]) begin
      vcnt[0]++;
      if (q0.size() == 0) check("dut0_unexpected_valid", 1, 0);
      else mon_compare(0, q0.pop_front());
    end
    if (ov[1]) begin
      vcnt[1]++;
      if (q1.size() == 0) check("dut1_unexpected_valid", 1, 0);
      else mon_compare(1, q1.pop_front());
    end
  end

  function automatic int floor256(input longint v);
    longint q;
    q = v / 256;
    if (v < 0 && (v % 256) != 0) q = q - 1;
    return int'(q);
  endfunction

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32767) return -32767;
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 8; k++) begin
        tgt[d][k] = 0;
        cur[d][k] = 0;
      end
  endtask

  // Mix with the current gains, then slew every gain toward its target.
  task automatic model_pass(input int l[2], input int r[2], input bit m, input int due);
    longint sl, sr;
    exp_t   e;
    int     dl;
    npass++;
    for (int d = 0; d < 2; d++) begin
      sl = 0;
      sr = 0;
      for (int s = 0; s < NS; s++) begin
        sl += longint'(l[s]) * cur[d][s*4+0] + longint'(r[s]) * cur[d][s*4+1];
        sr += longint'(l[s]) * cur[d][s*4+2] + longint'(r[s]) * cur[d][s*4+3];
      end
      e.l   = m ? 0 : sat(floor256(sl));
      e.r   = m ? 0 : sat(floor256(sr));
      e.due = due;
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
      for (int k = 0; k < 8; k++) begin
        dl = tgt[d][k] - cur[d][k];
        if (rstep[d] == 0) cur[d][k] = tgt[d][k];
        else if (dl > rstep[d]) cur[d][k] += rstep[d];
        else if (dl < -rstep[d]) cur[d][k] -= rstep[d];
        else cur[d][k] = tgt[d][k];
      end
    end
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 3'(addr);
    cfg_data = 8'(data);
    for (int d = 0; d < 2; d++) tgt[d][addr] = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drive_inputs(input int l[2], input int r[2], input bit m);
    src_left_in  = {16'(l[1]), 16'(l[0])};
    src_right_in = {16'(r[1]), 16'(r[0])};
    mute         = m;
  endtask

  // Issue one accepted strobe; returns in the cycle before out_valid.
  task automatic strobe_pass(input int l0, input int r0, input int l1, input int r1, input bit m);
    int l[2];
    int r[2];
    l = '{l0, l1};
    r = '{r0, r1};
    @(negedge clk);
    drive_inputs(l, r, m);
    sample_strobe = 1'b1;
    model_pass(l, r, m, cyc + 10);
    @(negedge clk);
    sample_strobe = 1'b0;
    src_left_in   = 32'($urandom);
    src_right_in  = 32'($urandom);
    mute          = ~m;
    check("busy_after_accept", int'(bz[0] & bz[1]), 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  int rs;
  int ramp_exp [5] = '{0, 4, 8, 10, 10};

  initial begin
    reset_n = 1'b0; sample_strobe = 1'b0; mute = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; overrun_clr = 1'b0;
    src_left_in = '0; src_right_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check("reset_left", int'(lo[d]), 0);
      check("reset_right", int'(ro[d]), 0);
      check("reset_valid", int'(ov[d]), 0);
      check("reset_busy", int'(bz[d]), 0);
      check("reset_overrun", int'(orun[d]), 0);
    end

    // Unity routing on source 0.
    cfg_write(0, 255);
    cfg_write(3, 255);
    strobe_pass(1000, -2000, 0, 0, 0);
    strobe_pass(1000, -2000, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("unity_left", int'(lo[0]), 996);
    check("unity_right", int'(ro[0]), -1993);

    // Ramp on l2l_0 from 0 to 10.
    do_reset();
    cfg_write(0, 10);
    for (int i = 0; i < 5; i++) begin
      strobe_pass(256, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      check($sformatf("ramp_pass%0d", i), int'(lo[1]), ramp_exp[i]);
    end

    // Saturation with every gain at 255, including back-to-back passes.
    for (int k = 0; k < 8; k++) cfg_write(k, 255);
    strobe_pass(32767, 32767, 32767, 32767, 0);
    strobe_pass(32767, 32767, 32767, 32767, 0);
    strobe_pass(-32768, -32768, -32768, -32768, 0);
    repeat (2) @(negedge clk);
    check("sat_neg_left", int'(lo[0]), -32767);
    check("sat_neg_right", int'(ro[0]), -32767);

    // Cross-feed r2l of source 1, then a muted pass while gains keep ramping.
    do_reset();
    cfg_write(5, 128);
    strobe_pass(0, 0, 0, -100, 0);
    strobe_pass(0, 0, 0, -100, 0);
    repeat (2) @(negedge clk);
    check("xfeed_left", int'(lo[0]), -50);
    check("xfeed_right", int'(ro[0]), 0);
    strobe_pass(300, 300, 300, 300, 1);
    strobe_pass(300, 300, 300, -100, 0);

    // Overrun: dropped strobe, set-beats-clear, then clear.
    repeat (2) @(negedge clk);
    @(negedge clk);
    drive_inputs('{500, 0}, '{0, -700}, 1'b0);
    sample_strobe = 1'b1;
    model_pass('{500, 0}, '{0, -700}, 1'b0, cyc + 10);
    @(negedge clk);
    sample_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    drive_inputs('{-9000, 9000}, '{9000, -9000}, 1'b0);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    check("overrun_set0", int'(orun[0]), 1);
    check("overrun_set1", int'(orun[1]), 1);
    @(negedge clk);
    sample_strobe = 1'b1;
    overrun_clr   = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    overrun_clr   = 1'b0;
    check("overrun_set_wins", int'(orun[0] & orun[1]), 1);
    @(negedge clk);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("overrun_cleared", int'(orun[0] | orun[1]), 0);
    repeat (3) @(negedge clk);

    // Reset in mid-pass aborts it.
    cfg_write(0, 200);
    strobe_pass(100, 100, 100, 100, 0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    drive_inputs('{4000, 4000}, '{4000, 4000}, 1'b0);
    sample_strobe = 1'b1;
    @(negedge clk);
    sample_strobe = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    for (int d = 0; d < 2; d++) begin
      check("abort_busy", int'(bz[d]), 0);
      check("abort_left", int'(lo[d]), 0);
      check("abort_right", int'(ro[d]), 0);
    end
    repeat (12) @(negedge clk);
    strobe_pass(12345, -12345, 2222, 3333, 0);

    // Randomised traffic.
    for (int it = 0; it < 40; it++) begin
      rs = $urandom_range(0, 3);
      for (int w = 0; w < rs; w++) cfg_write($urandom_range(0, 7), $urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0)
        strobe_pass(32767, -32768, 32767, -32768, 1'($urandom_range(0, 1)));
      else
        strobe_pass(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                    ($urandom_range(0, 7) == 0));
    end

    repeat (12) @(negedge clk);
    check("dut0_pending", q0.size(), 0);
    check("dut1_pending", q1.size(), 0);
    check("dut0_valid_count", vcnt[0], npass);
    check("dut1_valid_count", vcnt[1], npass);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
